// File: rtl/tiny1_mmio_irq_if.sv
// tiny1_mmio_irq_if: core memory-port and interrupt handshake between tiny1 and its MMIO block
interface tiny1_mmio_irq_if;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_i;
  logic [15:0] mmio_data_o;
  logic mem_wr;
  logic mem_rd;
  logic mmio_hit;
  logic irq;
  logic irqack;
  modport master (
    output mem_addr, mem_data_i, mem_wr, mem_rd, irqack,
    input  mmio_data_o, mmio_hit, irq
  );
  modport slave (
    input  mem_addr, mem_data_i, mem_wr, mem_rd, irqack,
    output mmio_data_o, mmio_hit, irq
  );
endinterface

// File: rtl/tiny1_mmio_irq.sv
// tiny1_mmio_irq: MMIO register block, down-counting timer and edge-triggered interrupt controller
module tiny1_mmio_irq #(
  parameter int NSRC = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  tiny1_mmio_irq_if.slave  bus,
  input  logic [NSRC-1:1]  irq_src,
  input  logic [15:0]      ext_in,
  output logic [15:0]      ext_out
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [NSRC-1:0] pend, mask, clr, set;
  logic [15:0] reload, count, ext1, ext2, rdata;
  logic en, auto_rl, warm, tick, step, fire;
  logic [PW-1:0] pcnt;
  logic [NSRC-1:1] s1, s2, s3, armed, rise;
  logic [2:0] idx;
  logic mapped, sel, wr, wr_ctrl;
  assign mapped = bus.mem_addr[15:14] != 2'b00;
  assign sel = bus.mem_addr[15:3] == 13'h0800;
  assign idx = bus.mem_addr[2:0];
  assign wr = bus.mem_wr & sel;
  assign wr_ctrl = wr & (idx == 3'd4);
  assign tick = pcnt == PW'(PRESCALE - 1);
  assign step = en & tick & ~wr_ctrl;
  assign fire = step & (count == 16'd0);
  // a source only fires after it has been seen low since reset
  assign rise = s2 & ~s3 & armed;
  assign clr = (wr & (idx == 3'd0)) ? bus.mem_data_i[NSRC-1:0] : '0;
  assign set = {rise, fire};
  always_comb begin
    rdata = '0;
    case (idx)
      3'd0: rdata = 16'(pend);
      3'd1: rdata = 16'(mask);
      3'd2: rdata = reload;
      3'd3: rdata = count;
      3'd4: rdata = {14'd0, auto_rl, en};
      3'd5: rdata = {14'd0, bus.irq, bus.irqack};
      3'd6: rdata = ext2;
      default: rdata = ext_out;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.mmio_data_o <= '0;
      bus.mmio_hit <= 1'b0;
    end else if (bus.mem_rd) begin
      bus.mmio_hit <= mapped;
      bus.mmio_data_o <= sel ? rdata : 16'd0;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      armed <= '0;
      warm <= 1'b0;
      ext1 <= '0;
      ext2 <= '0;
    end else begin
      s1 <= irq_src;
      s2 <= s1;
      s3 <= s2;
      warm <= 1'b1;
      armed <= armed | ({(NSRC-1){warm}} & ~s1);
      ext1 <= ext_in;
      ext2 <= ext1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend <= '0;
      bus.irq <= 1'b0;
    end else begin
      pend <= (pend & ~clr) | set;
      bus.irq <= |(pend & mask);
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mask <= '0;
      reload <= '0;
      ext_out <= '0;
    end else if (wr) begin
      if (idx == 3'd1) mask <= bus.mem_data_i[NSRC-1:0];
      if (idx == 3'd2) reload <= bus.mem_data_i;
      if (idx == 3'd7) ext_out <= bus.mem_data_i;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      en <= 1'b0;
      auto_rl <= 1'b0;
      count <= '0;
      pcnt <= '0;
    end else if (wr_ctrl) begin
      en <= bus.mem_data_i[0];
      auto_rl <= bus.mem_data_i[1];
      if (bus.mem_data_i[0]) begin
        count <= reload;
        pcnt <= '0;
      end
    end else if (en) begin
      pcnt <= tick ? '0 : pcnt + PW'(1);
      if (step) count <= (count == 16'd0) ? (auto_rl ? reload : count) : count - 16'd1;
      if (fire & ~auto_rl) en <= 1'b0;
    end
endmodule

// File: tb/tb_tiny1_mmio_irq.sv
// tb_tiny1_mmio_irq: directed and randomized checks of tiny1_mmio_irq against a behavioural model
module tb_tiny1_mmio_irq;
  localparam int NSRC = 8;
  localparam int P = 1;
  localparam logic [15:0] NM = 16'((1 << NSRC) - 1);
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NSRC-1:1] irq_src = '0;
  logic [15:0] ext_in = '0;
  logic [15:0] ext_out;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  tiny1_mmio_irq_if bus();
  tiny1_mmio_irq #(.NSRC(NSRC), .PRESCALE(P)) dut (
    .clk(clk), .rst(rst), .bus(bus), .irq_src(irq_src), .ext_in(ext_in), .ext_out(ext_out)
  );
  logic [15:0] m_pend, m_mask, m_reload, m_count, m_ext_out, m_data, ep1, ep2;
  bit m_en, m_auto, m_irq, m_hit;
  int m_phase, nprev;
  logic [NSRC-1:1] sp1, sp2, sp3;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_mask = 0; m_reload = 0; m_count = 0; m_ext_out = 0; m_data = 0;
    m_en = 0; m_auto = 0; m_irq = 0; m_hit = 0; m_phase = 0; nprev = 0;
    sp1 = '0; sp2 = '0; sp3 = '0; ep1 = 0; ep2 = 0;
  endtask

  function automatic logic [15:0] rd_model(input logic [15:0] a);
    case (a)
      16'h4000: return m_pend;
      16'h4001: return m_mask;
      16'h4002: return m_reload;
      16'h4003: return m_count;
      16'h4004: return {14'd0, m_auto, m_en};
      16'h4005: return {14'd0, m_irq, bus.irqack};
      16'h4006: return ep2;
      16'h4007: return m_ext_out;
      default: return 16'h0;
    endcase
  endfunction

  // evaluates the register-map rules for the coming edge using pre-edge state
  task automatic model_edge();
    logic [15:0] a, d, clr, nd, n_mask, n_reload, n_ext, n_count;
    logic [NSRC-1:1] rise;
    bit w, nh, n_irq, n_en, n_auto, fire;
    int n_phase;
    a = bus.mem_addr; d = bus.mem_data_i;
    w = bus.mem_wr && a >= 16'h4000 && a <= 16'h4007;
    nd = m_data; nh = m_hit;
    if (bus.mem_rd) begin
      nh = a >= 16'h4000;
      nd = rd_model(a);
    end
    n_irq = (m_pend & m_mask) != 0;
    clr = (w && a == 16'h4000) ? d & NM : 16'h0;
    n_mask = (w && a == 16'h4001) ? d & NM : m_mask;
    n_reload = (w && a == 16'h4002) ? d : m_reload;
    n_ext = (w && a == 16'h4007) ? d : m_ext_out;
    n_en = m_en; n_auto = m_auto; n_count = m_count; n_phase = m_phase; fire = 0;
    if (w && a == 16'h4004) begin
      n_en = d[0]; n_auto = d[1];
      if (d[0]) begin n_count = m_reload; n_phase = 0; end
    end else if (m_en) begin
      if (m_phase == P - 1) begin
        n_phase = 0;
        if (m_count == 0) begin
          fire = 1;
          if (m_auto) n_count = m_reload; else n_en = 0;
        end else n_count = m_count - 16'd1;
      end else n_phase = m_phase + 1;
    end
    rise = nprev >= 3 ? sp2 & ~sp3 : '0;
    m_pend = (m_pend & ~clr) | 16'({rise, fire});
    m_data = nd; m_hit = nh; m_irq = n_irq; m_mask = n_mask; m_reload = n_reload;
    m_ext_out = n_ext; m_en = n_en; m_auto = n_auto; m_count = n_count; m_phase = n_phase;
    sp3 = sp2; sp2 = sp1; sp1 = irq_src; nprev++;
    ep2 = ep1; ep1 = ext_in;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("rdata", bus.mmio_data_o, m_data);
    check("hit", {15'd0, bus.mmio_hit}, {15'd0, m_hit});
    check("irq", {15'd0, bus.irq}, {15'd0, m_irq});
    check("ext_out", ext_out, m_ext_out);
  endtask

  task automatic cyc(input bit w, input bit r, input logic [15:0] a, input logic [15:0] d);
    bus.mem_wr = w; bus.mem_rd = r; bus.mem_addr = a; bus.mem_data_i = d;
    step();
    bus.mem_wr = 0; bus.mem_rd = 0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    cyc(1, 0, a, d);
  endtask

  task automatic rd(input logic [15:0] a);
    cyc(0, 1, a, 16'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 16'h0, 16'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdata"}, bus.mmio_data_o, 16'h0);
    check({tag, "_hit"}, {15'd0, bus.mmio_hit}, 16'h0);
    check({tag, "_irq"}, {15'd0, bus.irq}, 16'h0);
    check({tag, "_ext_out"}, ext_out, 16'h0);
  endtask

  initial begin
    int first, last, n;
    bus.mem_addr = 0; bus.mem_data_i = 0; bus.mem_wr = 0; bus.mem_rd = 0; bus.irqack = 0;
    model_reset();
    #2 rst = 1;
    #1 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    wr(16'h4001, 16'h00FF);
    rd(16'h4001);
    check("mask_rd", bus.mmio_data_o, 16'h00FF);
    check("mask_hit", {15'd0, bus.mmio_hit}, 16'h1);
    rd(16'h0010);
    check("ram_hit", {15'd0, bus.mmio_hit}, 16'h0);
    check("ram_rdata", bus.mmio_data_o, 16'h0);
    wr(16'h4001, 16'h0001);
    wr(16'h4002, 16'h0003);
    wr(16'h4004, 16'h0003);
    first = 0; last = 0; n = 0;
    for (int j = 1; j <= 20; j++) begin
      cyc(1, 1, 16'h4000, 16'h0001);
      if (bus.mmio_data_o[0]) begin
        if (first == 0) first = j;
        else check("t2_period", 16'(j - last), 16'd4);
        last = j;
        n++;
      end
    end
    check("t2_first", 16'(first), 16'd5);
    check("t2_count", 16'(n), 16'd4);
    wr(16'h4004, 16'h0000);
    wr(16'h4000, 16'hFFFF);
    wr(16'h4001, 16'h0004);
    idle(2);
    irq_src[2] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      idle(1);
      check("src_irq_lat", {15'd0, bus.irq}, {15'd0, j == 3});
    end
    idle(6);
    irq_src[2] = 1'b0;
    rd(16'h4000);
    check("src_pend", bus.mmio_data_o, 16'h0004);
    wr(16'h4000, 16'h0004);
    idle(5);
    rd(16'h4000);
    check("src_once", bus.mmio_data_o, 16'h0000);
    irq_src[3] = 1'b1;
    idle(2);
    wr(16'h4000, 16'h0008);
    rd(16'h4000);
    check("set_wins", bus.mmio_data_o & 16'h0008, 16'h0008);
    irq_src[3] = 1'b0;
    wr(16'h4000, 16'hFFFF);
    wr(16'h4001, 16'h0001);
    wr(16'h4002, 16'h0005);
    wr(16'h4004, 16'h0001);
    idle(8);
    rd(16'h4004);
    check("oneshot_ctrl", bus.mmio_data_o, 16'h0000);
    rd(16'h4003);
    check("oneshot_count", bus.mmio_data_o, 16'h0000);
    rd(16'h4000);
    check("oneshot_pend", bus.mmio_data_o, 16'h0001);
    wr(16'h4000, 16'h0001);
    idle(10);
    rd(16'h4000);
    check("oneshot_single", bus.mmio_data_o, 16'h0000);
    wr(16'h4007, 16'hA5A5);
    wr(16'h4002, 16'h0003);
    wr(16'h4004, 16'h0003);
    idle(6);
    rd(16'h4002);
    check("pre_rst_irq", {15'd0, bus.irq}, 16'h1);
    irq_src = '1;
    @(negedge clk);
    #2 rst = 1;
    #1 check_reset_outputs("async_rst");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    idle(8);
    rd(16'h4000);
    check("held_silent", bus.mmio_data_o, 16'h0000);
    irq_src = '0;
    idle(3);
    irq_src = '1;
    idle(5);
    rd(16'h4000);
    check("rearmed", bus.mmio_data_o, 16'h00FE);
    wr(16'h4000, 16'hFFFF);
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] a, d;
      int s;
      s = $urandom_range(0, 9);
      a = s < 6 ? 16'h4000 + 16'($urandom_range(0, 7)) :
          s < 8 ? 16'($urandom_range(0, 16'h3FFF)) : 16'($urandom_range(16'h4008, 16'hFFFF));
      d = $urandom_range(0, 3) == 0 ? 16'($urandom) : 16'($urandom_range(0, 15));
      bus.irqack = 1'($urandom_range(0, 1));
      ext_in = 16'($urandom);
      if ($urandom_range(0, 7) == 0) irq_src = irq_src ^ ((NSRC-1)'(1) << $urandom_range(0, NSRC - 2));
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, a, d);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tiny1_mmio_irq.md
# tiny1_mmio_irq

Memory-mapped I/O responder and interrupt controller on the far side of the tiny1 core's single memory port. It decodes core accesses to the mapped region (0x4000–0xFFFF) and serves reads with the one-cycle latency the core's after-read cycle expects. It commits writes in the core's write cycle and drives the core's `irq` line from a maskable pending register fed by a down-counting timer and external edge sources. RAM (0x0000–0x3FFF) is served elsewhere; the top level muxes `mem_data_i` using `mmio_hit`.

## Interface
- `NSRC`, 8: interrupt sources; bit 0 is the timer, bits 1..NSRC-1 come from `irq_src[NSRC-1:1]`; range 2–16.
- `PRESCALE`, 1: clock cycles per timer tick; minimum 1.

- `clk`  in  1  clock
- `rst`  in  1  one clock; reset is asynchronous and active-high
- `mem_addr`  in  16  core access address
- `mem_data_i`  in  16  core write data (core's `mem_data_o`)
- `mem_wr`  in  1  write strobe, single cycle
- `mem_rd`  in  1  read strobe
- `mmio_data_o`  out  16  registered read data (to core's `mem_data_i` mux)
- `mmio_hit`  out  1  registered: last sampled read was in the mapped region
- `irq`  out  1  interrupt request to core
- `irqack`  in  1  core in IRQ mode
- `irq_src`  in  NSRC-1  asynchronous external sources, rising-edge sensitive
- `ext_in`  in  16  general input port, asynchronous
- `ext_out`  out  16  general output port

## Operation
- Decode: mapped when `mem_addr[15:14]!=0`; register index is `mem_addr[2:0]`; addresses 0x4008 and above read 0 and ignore writes. Unmapped (RAM) accesses do not change any state.
- Register map:
  - 0x4000 PEND: read pending; write-1-to-clear.
  - 0x4001 MASK: RW, low NSRC bits.
  - 0x4002 RELOAD: RW 16.
  - 0x4003 COUNT: RO.
  - 0x4004 CTRL: bit0 EN, bit1 AUTO; RW.
  - 0x4005 STAT: RO, bit0 `irqack`, bit1 `irq`.
  - 0x4006 EXT_IN: RO, synchronised `ext_in`.
  - 0x4007 EXT_OUT: RW, drives `ext_out`.
  - Unimplemented bits read 0.
- Reads: no side effects.
- Writes to RO registers: ignored.
- Writing CTRL with EN=1 loads COUNT<=RELOAD and restarts the prescaler. Writing EN=0 stops the timer and freezes COUNT.
- Timer: on each tick with EN=1:
  - If COUNT==0: set PEND[0]. With AUTO=1, COUNT<=RELOAD; with AUTO=0, EN<=0.
  - Otherwise COUNT<=COUNT-1.
  - Expiry period is (RELOAD+1)·PRESCALE cycles. RELOAD=0 with AUTO fires every tick.
- Sources: each `irq_src` bit passes through a 2-flop synchroniser and then a rising-edge detector (sync2 & ~sync3); a detected edge sets its PEND bit. A level held high sets PEND only once.
- Simultaneous set and W1C of the same PEND bit in one cycle: set wins.
- `irq` <= |(PEND & MASK), registered. The core samples `irq` only outside IRQ mode, so `irq` stays level while `irqack` is high. After the handler clears PEND, `irq` drops. If sources remain pending when `irqack` falls, `irq` is still high and the core re-enters.
- `ext_in` uses a 2-flop synchroniser; EXT_IN reads the second flop.

## Timing
- Read: when `mem_rd`=1 with a mapped address at edge n, `mmio_data_o` and `mmio_hit`=1 are valid after edge n and held until the next sampled `mem_rd`. A sampled `mem_rd` with an unmapped address gives `mmio_hit`=0 and `mmio_data_o`=0. Reads return the pre-edge register value.
- Write: committed at the edge where `mem_wr`=1; visible to a read sampled at the next edge. If `mem_wr` and `mem_rd` are both high, the write commits and the read returns the old value.
- Source edge: rising before edge k gives PEND set at k+2 and `irq` at k+3.
- Timer expiry: PEND[0] is set at the tick edge; `irq` follows one edge later when MASK[0]=1.
- Reset (async, any time): all registers 0, EN=0, synchronisers 0. Outputs `mmio_data_o`=0, `mmio_hit`=0, `irq`=0, `ext_out`=0. Sources already high at reset release do not fire until they fall and rise again.

## Test plan
- Write 0x00FF to MASK, then read MASK -> `mmio_data_o`=0x00FF and `mmio_hit`=1 one edge after the read address; a read of 0x0010 gives `mmio_hit`=0.
- MASK=0x01, RELOAD=3, CTRL=0x3, PRESCALE=1 -> PEND[0] sets every 4 cycles, `irq` rises one edge later; W1C 0x0001 drops `irq` within 1 edge unless it coincides with an expiry.
- Pulse `irq_src[2]` high for 10 cycles with MASK=0x04 -> PEND=0x0004 at k+2 and `irq` at k+3, exactly once.
- Set-vs-clear collision: W1C PEND[3] in the same cycle a `irq_src[3]` edge is detected -> PEND[3] remains 1.
- One-shot: RELOAD=5, CTRL=0x1 -> a single PEND[0] after 6 ticks, then CTRL reads 0x0 and COUNT holds 0.
- Assert `rst` mid-countdown while `irq`=1 -> all outputs 0 immediately, with no clock required; held-high sources stay silent after release.
